boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width (DEPTH = 2**ADDR_W words).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  incoming byte from serial receiver.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-008 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-009 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-010 SHALL have port core_rst  output  1  hold-in-reset for the processor core, active-high.
REQ-011 SHALL have port done  output  1  image loaded and verified; core released.
REQ-012 SHALL have port error  output  1  load failed; core held.

Function
REQ-013 SHALL accept a byte only on a rising edge where rx_valid=1 and rx_ready=1; rx_data SHALL be ignored otherwise.
REQ-014 SHALL implement states LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR.
REQ-015 SHALL drive rx_ready=1 in LEN0, LEN1, DATA and CSUM, and rx_ready=0 in WRITE, DONE and ERROR.
REQ-016 LEN0: accepted byte SHALL become N[7:0]; next state LEN1.
REQ-017 LEN1: accepted byte SHALL become N[15:8]; next state: ERROR if N > DEPTH, CSUM if N = 0, otherwise DATA.
REQ-018 DATA: SHALL assemble bytes little-endian (first byte = bits 7:0) via a 2-bit byte counter; after the 4th byte, next state WRITE.
REQ-019 WRITE: SHALL last exactly one cycle with mem_we=1, mem_addr = word index, mem_wdata = assembled word.
REQ-020 After WRITE, the word index SHALL increment; next state DATA if words written < N, otherwise CSUM.
REQ-021 mem_we SHALL be 0 in every state except WRITE.
REQ-022 SHALL hold a running 8-bit XOR of all DATA bytes only (length bytes excluded), cleared by reset.
REQ-023 CSUM: accepted byte equal to the running XOR SHALL go to DONE; otherwise ERROR.
REQ-024 The word index SHALL be ADDR_W+1 bits wide internally so that N = DEPTH completes without wrap; mem_addr SHALL be its low ADDR_W bits.
REQ-025 DONE and ERROR SHALL be terminal until RST; later rx_valid activity SHALL have no effect.
REQ-026 core_rst SHALL be 1 in every state except DONE; done=1 only in DONE; error=1 only in ERROR.
REQ-027 Latency: last data byte accepted at edge k -> mem_we high during cycle k..k+1; checksum byte accepted at edge j -> done/core_rst change visible after edge j.

Reset
REQ-028 RST=1 SHALL immediately and asynchronously force state LEN0, byte counter 0, word index 0, checksum 0, N 0, assembled word 0.
REQ-029 While RST=1: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, error=0.
REQ-030 RST asserted mid-load (any state) SHALL abort the load with no further memory write; reload restarts at LEN0 on RST release.

Verification
REQ-031 Bytes 02 00 13 05 10 00 93 05 20 00 B0 -> writes 0x00100513 @0 and 0x00200593 @1, then done=1, core_rst=0, error=0.
REQ-032 Same stream with final byte B1 -> both words written, then error=1, done=0, core_rst=1.
REQ-033 Bytes 00 00 00 (N=0, checksum 00) -> no mem_we pulse, done=1.
REQ-034 ADDR_W=8, bytes 01 01 (N=257) -> error=1 after 2nd byte, no mem_we pulse, rx_ready=0 thereafter.
REQ-035 rx_valid toggled randomly with gaps during REQ-031 stream -> identical writes and result; rx_ready=0 during each WRITE cycle, and no byte is lost.
REQ-036 RST pulsed after 5 bytes of REQ-031 stream, then full stream resent -> at most one write (@0) before abort; final memory and done=1 as in REQ-031.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed, XOR-checksummed image from a byte receiver into instruction memory
// Ports: CLK/RST (async active-high); rx_data/rx_valid/rx_ready byte handshake;
//        mem_we/mem_addr/mem_wdata instruction-memory write port;
//        core_rst holds the core until the image verifies; done/error report the outcome.
module boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);
  localparam logic [2:0] S_LEN0  = 3'd0;
  localparam logic [2:0] S_LEN1  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);
  logic [2:0]      r_state;
  logic [1:0]      r_cnt;
  logic [ADDR_W:0] r_idx;
  logic [7:0]      r_csum;
  logic [15:0]     r_len;
  logic [31:0]     r_word;
  logic            w_acc;
  logic [16:0]     w_n;
  logic [ADDR_W:0] w_idx_nx;
  logic            w_more;
  // rx_ready is gated by RST so it drops the instant reset asserts, not at the next edge
  assign rx_ready  = ~RST & (r_state == S_LEN0 | r_state == S_LEN1 | r_state == S_DATA | r_state == S_CSUM);
  assign w_acc     = rx_valid & rx_ready;
  assign w_n       = {1'b0, rx_data, r_len[7:0]};
  assign w_idx_nx  = r_idx + 1'b1;
  assign w_more    = 17'(w_idx_nx) < {1'b0, r_len};
  assign mem_we    = r_state == S_WRITE;
  assign mem_addr  = r_idx[ADDR_W-1:0];
  assign mem_wdata = r_word;
  assign core_rst  = r_state != S_DONE;
  assign done      = r_state == S_DONE;
  assign error     = r_state == S_ERROR;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_LEN0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
      r_len   <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        S_LEN0: if (w_acc) begin
          r_len[7:0] <= rx_data;
          r_state    <= S_LEN1;
        end
        S_LEN1: if (w_acc) begin
          r_len[15:8] <= rx_data;
          r_state     <= w_n > DEPTH ? S_ERROR : w_n == '0 ? S_CSUM : S_DATA;
        end
        S_DATA: if (w_acc) begin
          // shifting in from the top leaves the first byte in bits 7:0 after four bytes
          r_word  <= {rx_data, r_word[31:8]};
          r_csum  <= r_csum ^ rx_data;
          r_cnt   <= r_cnt + 2'd1;
          r_state <= r_cnt == 2'd3 ? S_WRITE : S_DATA;
        end
        S_WRITE: begin
          r_idx   <= w_idx_nx;
          r_state <= w_more ? S_DATA : S_CSUM;
        end
        S_CSUM: if (w_acc) r_state <= rx_data == r_csum ? S_DONE : S_ERROR;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed byte streams with a write scoreboard checked by an independent monitor
module tb_boot_loader;
  logic        CLK = 0;
  logic        RST = 1;
  logic [7:0]  rx_data = 0;
  logic        rx_valid = 0;
  logic        rx_ready, mem_we, core_rst, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  good[11] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
  boot_loader #(.ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .done(done), .error(error)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (!RST && mem_we) begin
      logic [39:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0h data=%08h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} != e) begin
          errors++;
          $display("FAIL write got addr=%0h data=%08h expected addr=%0h data=%08h", mem_addr, mem_wdata, e[39:32], e[31:0]);
        end
      end
      checks++;
      if (rx_ready) begin
        errors++;
        $display("FAIL ready_in_write got 1 expected 0");
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      @(negedge CLK);
      rx_valid = 0;
      rx_data  = 8'($urandom);
    end
    @(negedge CLK);
    rx_valid = 1;
    rx_data  = b;
    while (!rx_ready && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 20) begin
      errors++;
      checks++;
      $display("FAIL send_timeout got rx_ready=0 expected 1");
    end
    @(posedge CLK);
    #1 rx_valid = 0;
  endtask
  task automatic run_good(input int n, input logic [7:0] last, input bit gaps);
    for (int i = 0; i < n; i++) send(i == 10 ? last : good[i], gaps);
  endtask
  task automatic push_writes();
    exp_q.push_back({8'h00, 32'h00100513});
    exp_q.push_back({8'h01, 32'h00200593});
  endtask
  task automatic pulse_reset();
    @(negedge CLK);
    #2 RST = 1;
    #1;
    chk("rst_ready", rx_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_core", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge CLK);
    RST = 0;
  endtask
  task automatic result(input string name, input bit d, input bit e);
    chk({name, "_done"}, done, d);
    chk({name, "_error"}, error, e);
    chk({name, "_core_rst"}, core_rst, !d);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask
  initial begin
    #1;
    chk("init_ready", rx_ready, 0);
    chk("init_core", core_rst, 1);
    pulse_reset();
    push_writes();
    run_good(11, 8'hB0, 0);
    result("good", 1, 0);
    @(negedge CLK);
    rx_valid = 1;
    rx_data  = 8'h55;
    repeat (4) @(negedge CLK);
    rx_valid = 0;
    chk("done_ready", rx_ready, 0);
    result("done_hold", 1, 0);
    pulse_reset();
    push_writes();
    run_good(11, 8'hB1, 0);
    result("badcsum", 0, 1);
    pulse_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    result("empty", 1, 0);
    pulse_reset();
    send(8'h01, 0);
    send(8'h01, 0);
    result("toolong", 0, 1);
    repeat (3) @(negedge CLK);
    chk("toolong_ready", rx_ready, 0);
    pulse_reset();
    push_writes();
    run_good(11, 8'hB0, 1);
    result("gaps", 1, 0);
    pulse_reset();
    run_good(5, 8'hB0, 0);
    chk("abort_core", core_rst, 1);
    pulse_reset();
    repeat (3) @(negedge CLK);
    push_writes();
    run_good(11, 8'hB0, 0);
    result("reload", 1, 0);
    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
